// File: rtl/timer_pkg.sv
// Shared definitions for the timer compare/interrupt block: read-select
// encodings, snapshot FSM states and the compare reset default.
package timer_pkg;

   localparam logic [2:0] SEL_TDR0  = 3'd0;
   localparam logic [2:0] SEL_TDR1  = 3'd1;
   localparam logic [2:0] SEL_TCMR0 = 3'd2;
   localparam logic [2:0] SEL_TCMR1 = 3'd3;
   localparam logic [2:0] SEL_TIER  = 3'd4;
   localparam logic [2:0] SEL_TISR  = 3'd5;

   localparam logic [63:0] CMP_RST_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } snap_state_t;

   // Single-bit status/enable registers read back as a zero-extended word.
   function automatic logic [31:0] flag_word(input logic flag);
      return {31'b0, flag};
   endfunction

endpackage

// File: rtl/cmp_match.sv
// 64-bit equality comparator between the live count and the compare value.
module cmp_match (
   input  logic [63:0] count,
   input  logic [63:0] cmp_val,
   output logic        match
);

   assign match = (count == cmp_val);

endmodule

// File: rtl/cmp_int.sv
// Timer compare/interrupt block with a register read port and a snapshot FSM
// that keeps 64-bit count reads coherent across two 32-bit accesses.
module cmp_int
   import timer_pkg::*;
#(
   parameter logic [63:0] CMP_RST = CMP_RST_DEFAULT
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [63:0] count,
   input  logic [31:0] wdata,
   input  logic        tcmr0_wr_sel,
   input  logic        tcmr1_wr_sel,
   input  logic        tier_wr_sel,
   input  logic        tisr_wr_sel,
   input  logic        rd_en,
   input  logic [2:0]  rd_sel,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        tim_int
);

   logic [31:0] tcmr0;
   logic [31:0] tcmr1;
   logic        int_en;
   logic        int_st;
   logic        match;
   logic [31:0] shadow;
   snap_state_t snap_state;

   cmp_match u_cmp_match (
      .count   (count),
      .cmp_val ({tcmr1, tcmr0}),
      .match   (match)
   );

   // A match sets the sticky status even if a clear write lands on the same edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tcmr0  <= CMP_RST[31:0];
         tcmr1  <= CMP_RST[63:32];
         int_en <= 1'b0;
         int_st <= 1'b0;
      end else begin
         if (tcmr0_wr_sel) tcmr0 <= wdata;
         if (tcmr1_wr_sel) tcmr1 <= wdata;
         if (tier_wr_sel)  int_en <= wdata[0];
         if (match)
            int_st <= 1'b1;
         else if (tisr_wr_sel && wdata[0])
            int_st <= 1'b0;
      end
   end

   assign tim_int = int_st & int_en;

   // TDR0 latches the upper half so a later TDR1 read returns the matching pair.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         snap_state <= ST_IDLE;
         shadow     <= 32'd0;
         rdata      <= 32'd0;
         rvalid     <= 1'b0;
      end else begin
         rvalid <= rd_en;
         rdata  <= 32'd0;
         if (rd_en) begin
            case (rd_sel)
               SEL_TDR0: begin
                  rdata      <= count[31:0];
                  shadow     <= count[63:32];
                  snap_state <= ST_HELD;
               end
               SEL_TDR1: begin
                  if (snap_state == ST_HELD) begin
                     rdata      <= shadow;
                     snap_state <= ST_IDLE;
                  end else begin
                     rdata <= count[63:32];
                  end
               end
               SEL_TCMR0: rdata <= tcmr0;
               SEL_TCMR1: rdata <= tcmr1;
               SEL_TIER:  rdata <= flag_word(int_en);
               SEL_TISR:  rdata <= flag_word(int_st);
               default:   rdata <= 32'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmp_int.sv
// Self-checking bench for cmp_int: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_cmp_int;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [63:0] count;
   logic [31:0] wdata;
   logic        tcmr0_wr_sel;
   logic        tcmr1_wr_sel;
   logic        tier_wr_sel;
   logic        tisr_wr_sel;
   logic        rd_en;
   logic [2:0]  rd_sel;
   logic [31:0] rdata;
   logic        rvalid;
   logic        tim_int;

   int checks = 0;
   int passed = 0;

   logic [63:0] m_cmp;
   logic        m_en;
   logic        m_st;
   logic        m_held;
   logic [31:0] m_shadow;
   logic [31:0] exp_rdata;
   logic        exp_rvalid;

   cmp_int dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .count        (count),
      .wdata        (wdata),
      .tcmr0_wr_sel (tcmr0_wr_sel),
      .tcmr1_wr_sel (tcmr1_wr_sel),
      .tier_wr_sel  (tier_wr_sel),
      .tisr_wr_sel  (tisr_wr_sel),
      .rd_en        (rd_en),
      .rd_sel       (rd_sel),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .tim_int      (tim_int)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   task automatic model_reset();
      m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en       = 1'b0;
      m_st       = 1'b0;
      m_held     = 1'b0;
      m_shadow   = 32'd0;
      exp_rdata  = 32'd0;
      exp_rvalid = 1'b0;
   endtask

   // Register-level view: reads see pre-edge state, then all writes commit.
   task automatic model_edge();
      logic        hit;
      logic [31:0] r;
      hit = (count == m_cmp);
      r   = 32'd0;
      exp_rvalid = rd_en;
      if (rd_en) begin
         case (rd_sel)
            3'd0: begin r = count[31:0]; m_shadow = count[63:32]; m_held = 1'b1; end
            3'd1: begin
               if (m_held) begin r = m_shadow; m_held = 1'b0; end
               else r = count[63:32];
            end
            3'd2: r = m_cmp[31:0];
            3'd3: r = m_cmp[63:32];
            3'd4: r = {31'b0, m_en};
            3'd5: r = {31'b0, m_st};
            default: r = 32'd0;
         endcase
      end
      exp_rdata = r;
      if (hit) m_st = 1'b1;
      else if (tisr_wr_sel && wdata[0]) m_st = 1'b0;
      if (tier_wr_sel)  m_en = wdata[0];
      if (tcmr0_wr_sel) m_cmp[31:0]  = wdata;
      if (tcmr1_wr_sel) m_cmp[63:32] = wdata;
   endtask

   task automatic cycle();
      model_edge();
      @(posedge sys_clk);
      #1;
      rd_en        = 1'b0;
      tcmr0_wr_sel = 1'b0;
      tcmr1_wr_sel = 1'b0;
      tier_wr_sel  = 1'b0;
      tisr_wr_sel  = 1'b0;
   endtask

   task automatic issue_read(input logic [2:0] sel);
      rd_en  = 1'b1;
      rd_sel = sel;
      cycle();
   endtask

   task automatic issue_write(input int which, input logic [31:0] d);
      wdata = d;
      case (which)
         0: tcmr0_wr_sel = 1'b1;
         1: tcmr1_wr_sel = 1'b1;
         2: tier_wr_sel  = 1'b1;
         default: tisr_wr_sel = 1'b1;
      endcase
      cycle();
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      model_reset();
      #3;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'd0 || tim_int !== 1'b0)
         $display("[TB] FAIL reset_outputs: got rvalid=%b rdata=%h tim_int=%b want 0/0/0", rvalid, rdata, tim_int);
      else passed++;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      issue_read(3'd2);
      checks++;
      if (rdata !== 32'hFFFF_FFFF || rvalid !== 1'b1)
         $display("[TB] FAIL reset_tcmr0: got %h/%b want ffffffff/1", rdata, rvalid);
      else passed++;
      issue_read(3'd3);
      checks++;
      if (rdata !== 32'hFFFF_FFFF)
         $display("[TB] FAIL reset_tcmr1: got %h want ffffffff", rdata);
      else passed++;
      issue_read(3'd5);
      checks++;
      if (rdata !== 32'd0)
         $display("[TB] FAIL reset_tisr: got %h want 00000000", rdata);
      else passed++;
      issue_read(3'd4);
      checks++;
      if (rdata !== 32'd0 || tim_int !== 1'b0)
         $display("[TB] FAIL reset_tier: got %h int=%b want 00000000 int=0", rdata, tim_int);
      else passed++;
   endtask

   task automatic test_compare_irq();
      int bad;
      bad = 0;
      count = 64'd0;
      issue_write(0, 32'd20);
      issue_write(1, 32'd0);
      issue_write(2, 32'd1);
      for (int c = 0; c <= 25; c++) begin
         count = 64'(c);
         cycle();
         checks++;
         if (tim_int !== (c >= 20)) begin
            $display("[TB] FAIL irq_rise count=%0d: got tim_int=%b want %b", c, tim_int, (c >= 20));
            bad++;
         end else passed++;
      end
      issue_write(3, 32'h1);
      checks++;
      if (tim_int !== 1'b0)
         $display("[TB] FAIL irq_clear: got tim_int=%b want 0", tim_int);
      else passed++;
      issue_read(3'd5);
      checks++;
      if (rdata !== 32'd0)
         $display("[TB] FAIL irq_clear_tisr: got %h want 00000000", rdata);
      else passed++;
   endtask

   task automatic test_snapshot();
      count = 64'h0000_0000_FFFF_FFFE;
      issue_read(3'd0);
      checks++;
      if (rdata !== 32'hFFFF_FFFE)
         $display("[TB] FAIL snap_tdr0: got %h want fffffffe", rdata);
      else passed++;
      count = count + 64'd1;
      cycle();
      count = count + 64'd1;
      cycle();
      count = count + 64'd1;
      issue_read(3'd1);
      checks++;
      if (rdata !== 32'h0000_0000)
         $display("[TB] FAIL snap_tdr1: got %h want 00000000", rdata);
      else passed++;
      // Wrap on the very edge of the TDR0 read.
      count = 64'h0000_0000_FFFF_FFFF;
      issue_read(3'd0);
      count = 64'h0000_0001_0000_0000;
      checks++;
      if (rdata !== 32'hFFFF_FFFF)
         $display("[TB] FAIL wrap_tdr0: got %h want ffffffff", rdata);
      else passed++;
      issue_read(3'd1);
      checks++;
      if (rdata !== 32'h0000_0000)
         $display("[TB] FAIL wrap_tdr1: got %h want 00000000", rdata);
      else passed++;
      issue_read(3'd1);
      checks++;
      if (rdata !== 32'h0000_0001)
         $display("[TB] FAIL idle_tdr1_live: got %h want 00000001", rdata);
      else passed++;
   endtask

   task automatic test_set_priority();
      count = 64'd20;
      issue_write(3, 32'h1);
      count = 64'd0;
      checks++;
      if (tim_int !== 1'b1)
         $display("[TB] FAIL set_priority: got tim_int=%b want 1", tim_int);
      else passed++;
      issue_read(3'd5);
      checks++;
      if (rdata !== 32'd1)
         $display("[TB] FAIL set_priority_tisr: got %h want 00000001", rdata);
      else passed++;
      issue_write(3, 32'h0);
      checks++;
      if (tim_int !== 1'b1)
         $display("[TB] FAIL w0_no_clear: got tim_int=%b want 1", tim_int);
      else passed++;
      issue_write(3, 32'h1);
   endtask

   task automatic test_masked();
      issue_write(2, 32'h0);
      count = 64'd20;
      cycle();
      count = 64'd0;
      checks++;
      if (tim_int !== 1'b0)
         $display("[TB] FAIL masked_int: got tim_int=%b want 0", tim_int);
      else passed++;
      issue_read(3'd5);
      checks++;
      if (rdata !== 32'd1)
         $display("[TB] FAIL masked_tisr: got %h want 00000001", rdata);
      else passed++;
      issue_write(2, 32'hFFFF_FFFF);
      checks++;
      if (tim_int !== 1'b1)
         $display("[TB] FAIL unmask_int: got tim_int=%b want 1", tim_int);
      else passed++;
      issue_read(3'd4);
      checks++;
      if (rdata !== 32'd1)
         $display("[TB] FAIL tier_readback: got %h want 00000001", rdata);
      else passed++;
      issue_write(2, 32'h0);
      issue_read(3'd5);
      checks++;
      if (rdata !== 32'd1 || tim_int !== 1'b0)
         $display("[TB] FAIL toggle_keeps_st: got tisr=%h int=%b want 00000001 int=0", rdata, tim_int);
      else passed++;
      issue_write(3, 32'h1);
   endtask

   task automatic test_read_before_write();
      issue_write(0, 32'h1234_5678);
      wdata        = 32'hCAFE_F00D;
      tcmr0_wr_sel = 1'b1;
      rd_en        = 1'b1;
      rd_sel       = 3'd2;
      cycle();
      checks++;
      if (rdata !== 32'h1234_5678)
         $display("[TB] FAIL rbw_old: got %h want 12345678", rdata);
      else passed++;
      issue_read(3'd2);
      checks++;
      if (rdata !== 32'hCAFE_F00D)
         $display("[TB] FAIL rbw_new: got %h want cafef00d", rdata);
      else passed++;
      for (int s = 6; s <= 7; s++) begin
         rd_en  = 1'b1;
         rd_sel = 3'(s);
         cycle();
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'd0)
            $display("[TB] FAIL reserved_sel%0d: got %h/%b want 00000000/1", s, rdata, rvalid);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         count  = {$urandom, $urandom};
         rd_en  = 1'b1;
         rd_sel = 3'(i % 6);
         model_edge();
         @(posedge sys_clk);
         #1;
         checks++;
         if (rvalid !== 1'b1 || rdata !== exp_rdata)
            $display("[TB] FAIL b2b_%0d: got %h/%b want %h/1", i, rdata, rvalid, exp_rdata);
         else passed++;
      end
      rd_en = 1'b0;
      cycle();
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'd0)
         $display("[TB] FAIL b2b_idle: got %h/%b want 00000000/0", rdata, rvalid);
      else passed++;
   endtask

   task automatic test_reset_held();
      count = 64'hAAAA_0001_0000_0002;
      issue_read(3'd0);
      checks++;
      if (rdata !== 32'h0000_0002)
         $display("[TB] FAIL held_tdr0: got %h want 00000002", rdata);
      else passed++;
      sys_rst_n = 1'b0;
      model_reset();
      #2;
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'd0 || tim_int !== 1'b0)
         $display("[TB] FAIL held_reset_out: got %h/%b int=%b want 00000000/0 int=0", rdata, rvalid, tim_int);
      else passed++;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      count = 64'h5555_0003_0000_0004;
      issue_read(3'd1);
      checks++;
      if (rdata !== 32'h5555_0003)
         $display("[TB] FAIL held_reset_tdr1: got %h want 55550003", rdata);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         count = ($urandom_range(0, 3) == 0) ? m_cmp : {$urandom, $urandom};
         wdata = ($urandom_range(0, 3) == 0) ? 32'(count[31:0]) : $urandom;
         tcmr0_wr_sel = ($urandom_range(0, 7) == 0);
         tcmr1_wr_sel = ($urandom_range(0, 7) == 0);
         tier_wr_sel  = ($urandom_range(0, 5) == 0);
         tisr_wr_sel  = ($urandom_range(0, 5) == 0);
         rd_en        = ($urandom_range(0, 3) != 0);
         rd_sel       = 3'($urandom_range(0, 7));
         cycle();
         checks++;
         if (rvalid !== exp_rvalid || rdata !== exp_rdata || tim_int !== (m_st & m_en))
            $display("[TB] FAIL random_%0d: got %h/%b int=%b want %h/%b int=%b",
                     i, rdata, rvalid, tim_int, exp_rdata, exp_rvalid, (m_st & m_en));
         else passed++;
      end
   endtask

   initial begin
      sys_rst_n    = 1'b0;
      count        = 64'd0;
      wdata        = 32'd0;
      tcmr0_wr_sel = 1'b0;
      tcmr1_wr_sel = 1'b0;
      tier_wr_sel  = 1'b0;
      tisr_wr_sel  = 1'b0;
      rd_en        = 1'b0;
      rd_sel       = 3'd0;
      model_reset();
      #1;
      test_reset();
      test_compare_irq();
      test_snapshot();
      test_set_priority();
      test_masked();
      test_read_before_write();
      test_back_to_back();
      test_reset_held();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
